// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the pipelined RV32I core.
// Registers the memory-stage payload with valid, stall (hold) and flush (bubble),
// a registered writeback-data mux and x0 write suppression.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            valid_in,
    input  logic            reg_wr_in,
    input  logic [RA_W-1:0] rd_in,
    input  logic [1:0]      mem_reg_in,
    input  logic [XLEN-1:0] alu_res_in,
    input  logic [XLEN-1:0] wrap_load_in,
    input  logic [XLEN-1:0] next_sel_addr_in,
    output logic            valid_out,
    output logic            reg_wr_out,
    output logic [RA_W-1:0] rd_out,
    output logic [1:0]      mem_reg_out,
    output logic [XLEN-1:0] alu_res_out,
    output logic [XLEN-1:0] wrap_load_out,
    output logic [XLEN-1:0] next_sel_address_out,
    output logic [XLEN-1:0] wb_data_out
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt_out
`endif
);

    logic            r_valid;
    logic            r_reg_wr;
    logic [RA_W-1:0] r_rd;
    logic [1:0]      r_mem_reg;
    logic [XLEN-1:0] r_alu_res;
    logic [XLEN-1:0] r_wrap_load;
    logic [XLEN-1:0] r_next_sel_addr;
    logic [XLEN-1:0] r_wb_data;

    logic            w_reg_wr;
    logic [XLEN-1:0] w_wb_data;

    // Writeback-data select and qualified write enable, resolved before capture.
    always_comb begin
        w_reg_wr = valid_in & reg_wr_in & (rd_in != '0);
        unique case (mem_reg_in)
            2'b00:   w_wb_data = alu_res_in;
            2'b01:   w_wb_data = wrap_load_in;
            2'b10:   w_wb_data = next_sel_addr_in;
            default: w_wb_data = '0;
        endcase
    end

    // Stage register: flush beats stall beats load; flush still captures payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid         <= 1'b0;
            r_reg_wr        <= 1'b0;
            r_rd            <= '0;
            r_mem_reg       <= 2'b00;
            r_alu_res       <= '0;
            r_wrap_load     <= '0;
            r_next_sel_addr <= '0;
            r_wb_data       <= '0;
        end else if (flush_in || !stall_in) begin
            r_valid         <= valid_in & ~flush_in;
            r_reg_wr        <= w_reg_wr & ~flush_in;
            r_rd            <= rd_in;
            r_mem_reg       <= mem_reg_in;
            r_alu_res       <= alu_res_in;
            r_wrap_load     <= wrap_load_in;
            r_next_sel_addr <= next_sel_addr_in;
            r_wb_data       <= w_wb_data;
        end
    end

    assign valid_out            = r_valid;
    assign reg_wr_out           = r_reg_wr;
    assign rd_out               = r_rd;
    assign mem_reg_out          = r_mem_reg;
    assign alu_res_out          = r_alu_res;
    assign wrap_load_out        = r_wrap_load;
    assign next_sel_address_out = r_next_sel_addr;
    assign wb_data_out          = r_wb_data;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    // An instruction retires when the stage holds a valid entry and is not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !stall_in) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt_out = r_retire_cnt;
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline register for the pipelined RV32I core, between the data-memory stage and register-file writeback. It registers the memory-stage payload: ALU result, aligned load data, next-PC, writeback select, destination register and write enable. It adds a valid bit, stall (hold) and flush (bubble insertion), a registered writeback-data mux, and x0 write suppression. An optional retire counter counts instructions leaving the stage.

## Interface
Parameters:
- XLEN, 32, datapath width of all data fields
- RA_W, 5, register-address width
- CNT_W, 32, retire-counter width (used only with the macro)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall_in  in  1  hold all stage contents this cycle
- flush_in  in  1  replace incoming instruction with a bubble
- valid_in  in  1  memory-stage instruction is valid
- reg_wr_in  in  1  instruction writes the register file
- rd_in  in  RA_W  destination register
- mem_reg_in  in  2  writeback select: 00 ALU, 01 load, 10 next-PC, 11 reserved
- alu_res_in  in  XLEN  ALU result
- wrap_load_in  in  XLEN  aligned/extended load data
- next_sel_addr_in  in  XLEN  PC+4 for link writes
- valid_out  out  1  stage holds a valid instruction
- reg_wr_out  out  1  register-file write enable (qualified)
- rd_out  out  RA_W  registered destination
- mem_reg_out  out  2  registered writeback select
- alu_res_out, wrap_load_out, next_sel_address_out  out  XLEN  registered payload
- wb_data_out  out  XLEN  registered writeback data
- retire_cnt_out  out  CNT_W  retired-instruction count (macro only)

## Operation
- Update priority, evaluated at each rising clk: flush_in > stall_in > load.
- Load (neither asserted): every field captures its input. valid_out <= valid_in.
- Stall: every register holds, including valid and wb_data.
- Flush: valid_out <= 0 and reg_wr_out <= 0. Payload fields (rd, mem_reg, data) capture their inputs as in a load; they are don't-care downstream.
- reg_wr_out is registered as valid_in & reg_wr_in & (rd_in != 0). A write to x0 never asserts it.
- wb_data_out is registered, selected from the inputs before capture by mem_reg_in:
  - 00 → alu_res_in
  - 01 → wrap_load_in
  - 10 → next_sel_addr_in
  - 11 → 0
- No arithmetic in the datapath. All fields are XLEN-bit pass-through.
- Flush with stall in the same cycle: flush wins, and the bubble is inserted.

## Timing
- Latency: exactly 1 cycle from input to every output on a load.
- All outputs are driven directly from flops. There is no combinational input-to-output path.
- Reset: all outputs go to 0 immediately on rst low, independent of clk:
  - valid_out, reg_wr_out, rd_out, mem_reg_out, all data outputs, wb_data_out
  - retire_cnt_out
- Reset release: the first capture happens on the first rising clk with rst high.
- Reset asserted mid-stall or mid-flush: reset overrides both.
- Back-to-back stalls: contents are held indefinitely, with no state decay.

## Configuration
- Macro MEM_WB_RETIRE_CNT_EN.
- Defined:
  - An internal CNT_W-bit counter increments on each rising clk where valid_out = 1 and stall_in = 0, i.e. an instruction leaves the stage. Flushed bubbles are never counted.
  - Wraps modulo 2^CNT_W. Reset to 0 by rst.
  - Driven on retire_cnt_out.
- Undefined: the counter logic and the retire_cnt_out port are absent, and CNT_W is ignored.

## Test plan
- Reset: hold rst=0 with random inputs → every output 0. Release, then load valid_in=1, reg_wr_in=1, rd_in=5, mem_reg_in=00, alu_res_in=0x0000_1234 → next cycle: valid_out=1, reg_wr_out=1, rd_out=5, wb_data_out=0x0000_1234.
- Writeback select: same cycle inputs alu=0xA, load=0xB, next-PC=0xC; sweep mem_reg_in over 00/01/10/11 on successive cycles → wb_data_out = 0xA, 0xB, 0xC, 0x0 one cycle later each.
- x0 suppression: valid_in=1, reg_wr_in=1, rd_in=0 → reg_wr_out=0 and valid_out=1.
- Stall: load alu=0x55, then stall_in=1 for 3 cycles with alu_res_in=0xFF → outputs stay 0x55 for all 3 cycles. Deassert → 0xFF one cycle later.
- Flush priority: flush_in=1, stall_in=1, valid_in=1, reg_wr_in=1, rd_in=3 → next cycle valid_out=0, reg_wr_out=0.
- Retire counter (macro defined, CNT_W=4): 17 consecutive valid loads with 2 interleaved stall cycles and 1 flush bubble → retire_cnt_out = 17 mod 16 = 1 after the last instruction leaves. Async reset mid-sequence → 0 immediately.
